// File: rtl/inputcond_pkg.sv
// rtl/inputcond_pkg.sv - shared constants, level type and parameter check for the input conditioner
package inputcond_pkg;

    localparam int DEFAULT_CHANNELS      = 4;
    localparam int DEFAULT_SYNC_STAGES   = 2;
    localparam int DEFAULT_COUNTER_WIDTH = 3;
    localparam int DEFAULT_WAIT_TIME     = 3;
    localparam int EVENT_COUNT_WIDTH     = 8;

    typedef enum logic {
        LVL_LOW  = 1'b0,
        LVL_HIGH = 1'b1
    } level_e;

    function automatic bit wait_time_valid(input int wait_time, input int counter_width);
        return (wait_time >= 1) && (wait_time < (1 << counter_width));
    endfunction

endpackage

// File: rtl/inputcond_channel.sv
// rtl/inputcond_channel.sv - one channel: synchroniser, debounce FSM, edge flags
// Optional event counter under INPUTCOND_EVENT_COUNT_EN.
module inputcond_channel
    import inputcond_pkg::*;
#(
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
    parameter int WAIT_TIME     = DEFAULT_WAIT_TIME
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_noisy,
    output logic o_cond,
    output logic o_pos,
    output logic o_neg
`ifdef INPUTCOND_EVENT_COUNT_EN
    ,
    input  logic                         i_count_clear,
    output logic [EVENT_COUNT_WIDTH-1:0] o_event_count
`endif
);

    localparam logic [COUNTER_WIDTH-1:0] WAIT_CNT = COUNTER_WIDTH'(WAIT_TIME);

    logic [SYNC_STAGES-1:0]   r_sync;
    level_e                   r_state;
    level_e                   w_state_next;
    logic [COUNTER_WIDTH-1:0] r_count;
    logic [COUNTER_WIDTH-1:0] w_count_next;
    logic                     r_pos;
    logic                     r_neg;
    logic                     w_pos_next;
    logic                     w_neg_next;
    logic                     w_synced;
    logic                     w_level;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign w_level  = (r_state == LVL_HIGH);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_noisy};
        end
    end

    // The counter only runs while synced disagrees with the accepted level.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_pos_next   = 1'b0;
        w_neg_next   = 1'b0;
        if (w_synced == w_level) begin
            w_count_next = '0;
        end else if (r_count == WAIT_CNT) begin
            w_state_next = w_synced ? LVL_HIGH : LVL_LOW;
            w_count_next = '0;
            w_pos_next   = w_synced;
            w_neg_next   = !w_synced;
        end else begin
            w_count_next = r_count + COUNTER_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= LVL_LOW;
            r_count <= '0;
            r_pos   <= 1'b0;
            r_neg   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_pos   <= w_pos_next;
            r_neg   <= w_neg_next;
        end
    end

    assign o_cond = w_level;
    assign o_pos  = r_pos;
    assign o_neg  = r_neg;

`ifdef INPUTCOND_EVENT_COUNT_EN
    logic [EVENT_COUNT_WIDTH-1:0] r_events;

    // Counts the visible positiveedge pulse; a clear in that same cycle wins.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_events <= '0;
        end else if (i_count_clear) begin
            r_events <= '0;
        end else if (r_pos && (r_events != '1)) begin
            r_events <= r_events + EVENT_COUNT_WIDTH'(1);
        end
    end

    assign o_event_count = r_events;
`endif

endmodule

// File: rtl/inputconditioner_multi.sv
// rtl/inputconditioner_multi.sv - multi-channel synchronise/debounce/edge-detect top
// Optional per-channel event counters under INPUTCOND_EVENT_COUNT_EN.
module inputconditioner_multi
    import inputcond_pkg::*;
#(
    parameter int CHANNELS      = DEFAULT_CHANNELS,
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
    parameter int WAIT_TIME     = DEFAULT_WAIT_TIME
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] noisysignal,
    output logic [CHANNELS-1:0] conditioned,
    output logic [CHANNELS-1:0] positiveedge,
    output logic [CHANNELS-1:0] negativeedge
`ifdef INPUTCOND_EVENT_COUNT_EN
    ,
    input  logic                                  count_clear,
    output logic [EVENT_COUNT_WIDTH*CHANNELS-1:0] event_count
`endif
);

    generate
        if (!wait_time_valid(WAIT_TIME, COUNTER_WIDTH)) begin : g_bad_wait
            $error("WAIT_TIME must satisfy 1 <= WAIT_TIME < 2**COUNTER_WIDTH");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("SYNC_STAGES must be at least 2");
        end
        if (CHANNELS < 1) begin : g_bad_channels
            $error("CHANNELS must be at least 1");
        end
    endgenerate

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        inputcond_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .COUNTER_WIDTH(COUNTER_WIDTH),
            .WAIT_TIME    (WAIT_TIME)
        ) u_channel (
            .i_clk        (clk),
            .i_rst        (reset),
            .i_noisy      (noisysignal[g]),
            .o_cond       (conditioned[g]),
            .o_pos        (positiveedge[g]),
            .o_neg        (negativeedge[g])
`ifdef INPUTCOND_EVENT_COUNT_EN
            ,
            .i_count_clear(count_clear),
            .o_event_count(event_count[EVENT_COUNT_WIDTH*g +: EVENT_COUNT_WIDTH])
`endif
        );
    end

endmodule

// File: tb/tb_inputconditioner_multi.sv
// tb/tb_inputconditioner_multi.sv - scoreboard bench for inputconditioner_multi (defaults, optional INPUTCOND_EVENT_COUNT_EN)
module tb_inputconditioner_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] noisysignal;
    logic [3:0] conditioned;
    logic [3:0] positiveedge;
    logic [3:0] negativeedge;
`ifdef INPUTCOND_EVENT_COUNT_EN
    logic        count_clear;
    logic [31:0] event_count;
`endif

    inputconditioner_multi dut (
        .clk         (clk),
        .reset       (reset),
        .noisysignal (noisysignal),
        .conditioned (conditioned),
        .positiveedge(positiveedge),
        .negativeedge(negativeedge)
`ifdef INPUTCOND_EVENT_COUNT_EN
        ,
        .count_clear (count_clear),
        .event_count (event_count)
`endif
    );

    always #10 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] pos;
        logic [3:0] neg;
        logic [3:0] cond;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] m_cond = 4'b0000;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input int c, input logic [3:0] p, input logic [3:0] n);
        exp_t e;
        m_cond = (m_cond | p) & ~n;
        e.cyc  = c;
        e.pos  = p;
        e.neg  = n;
        e.cond = m_cond;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if ((positiveedge | negativeedge) != 4'b0000) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", {56'd0, positiveedge, negativeedge}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("event_cycle", 64'(cyc), 64'(e.cyc));
                chk("event_pos", 64'(positiveedge), 64'(e.pos));
                chk("event_neg", 64'(negativeedge), 64'(e.neg));
                chk("event_cond", 64'(conditioned), 64'(e.cond));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        reset       = 1'b1;
        noisysignal = 4'b0000;
`ifdef INPUTCOND_EVENT_COUNT_EN
        count_clear = 1'b0;
`endif
        tick(3);
        chk("reset_cond", 64'(conditioned), 64'd0);
        chk("reset_pos", 64'(positiveedge), 64'd0);
        chk("reset_neg", 64'(negativeedge), 64'd0);
`ifdef INPUTCOND_EVENT_COUNT_EN
        chk("reset_event_count", 64'(event_count), 64'd0);
`endif
        reset = 1'b0;
        tick(2);

        // Clean step on channel 0, rise then fall
        noisysignal[0] = 1'b1;
        expect_ev(cyc + 6, 4'b0001, 4'b0000);
        tick(10);
        noisysignal[0] = 1'b0;
        expect_ev(cyc + 6, 4'b0000, 4'b0001);
        tick(10);

        // Glitches of 2 and WAIT_TIME cycles are filtered, WAIT_TIME+1 is accepted
        noisysignal[1] = 1'b1;
        tick(2);
        noisysignal[1] = 1'b0;
        tick(10);
        chk("glitch2_cond", 64'(conditioned), 64'(m_cond));
        noisysignal[1] = 1'b1;
        tick(3);
        noisysignal[1] = 1'b0;
        tick(10);
        chk("glitch3_cond", 64'(conditioned), 64'(m_cond));
        c = cyc;
        noisysignal[1] = 1'b1;
        expect_ev(c + 6, 4'b0010, 4'b0000);
        tick(4);
        noisysignal[1] = 1'b0;
        expect_ev(c + 10, 4'b0000, 4'b0010);
        tick(12);

        // Bounce on channel 2: 1,0,1,0,1 then hold
        for (int i = 0; i < 5; i++) begin
            noisysignal[2] = (i % 2 == 0);
            if (i < 4) tick(1);
        end
        expect_ev(cyc + 6, 4'b0100, 4'b0000);
        tick(10);
        chk("bounce_cond", 64'(conditioned), 64'h4);
        noisysignal[2] = 1'b0;
        expect_ev(cyc + 6, 4'b0000, 4'b0100);
        tick(10);

        // Simultaneous steps on channels 0 and 3
        noisysignal = 4'b1001;
        expect_ev(cyc + 6, 4'b1001, 4'b0000);
        tick(10);
        noisysignal = 4'b0000;
        expect_ev(cyc + 6, 4'b0000, 4'b1001);
        tick(10);

        // Reset while channel 0 is counting and channel 3 is high
        noisysignal[3] = 1'b1;
        expect_ev(cyc + 6, 4'b1000, 4'b0000);
        tick(10);
        noisysignal[0] = 1'b1;
        tick(2);
        reset = 1'b1;
        #1;
        chk("midreset_cond", 64'(conditioned), 64'd0);
        chk("midreset_pos", 64'(positiveedge), 64'd0);
        chk("midreset_neg", 64'(negativeedge), 64'd0);
        m_cond = 4'b0000;
        tick(3);
        chk("held_reset_cond", 64'(conditioned), 64'd0);
        reset = 1'b0;
        expect_ev(cyc + 6, 4'b1001, 4'b0000);
        tick(10);
        noisysignal = 4'b0000;
        expect_ev(cyc + 6, 4'b0000, 4'b1001);
        tick(10);

`ifdef INPUTCOND_EVENT_COUNT_EN
        for (int k = 0; k < 300; k++) begin
            c = cyc;
            noisysignal[1] = 1'b1;
            expect_ev(c + 6, 4'b0010, 4'b0000);
            tick(5);
            noisysignal[1] = 1'b0;
            expect_ev(c + 11, 4'b0000, 4'b0010);
            tick(5);
        end
        tick(10);
        chk("evcnt_saturate", 64'(event_count[15:8]), 64'd255);
        count_clear = 1'b1;
        tick(1);
        count_clear = 1'b0;
        chk("evcnt_clear_all", 64'(event_count), 64'd0);

        // Clear held across the edge that raises positiveedge and the pulse cycle
        c = cyc;
        noisysignal[1] = 1'b1;
        expect_ev(c + 6, 4'b0010, 4'b0000);
        tick(5);
        count_clear = 1'b1;
        tick(2);
        count_clear = 1'b0;
        tick(5);
        chk("evcnt_clear_priority", 64'(event_count[15:8]), 64'd0);
        noisysignal[1] = 1'b0;
        expect_ev(cyc + 6, 4'b0000, 4'b0010);
        tick(10);
        noisysignal[1] = 1'b1;
        expect_ev(cyc + 6, 4'b0010, 4'b0000);
        tick(10);
        chk("evcnt_after_clear", 64'(event_count[15:8]), 64'd1);
`endif

        tick(5);
        chk("final_cond", 64'(conditioned), 64'(m_cond));
        chk("pending_events", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inputconditioner_multi.md
# inputconditioner_multi

Parametrised, multi-channel input conditioner. Each of CHANNELS asynchronous, noisy inputs (switches, buttons, external strobes) is synchronised into the `clk` domain, debounced with a programmable wait time, and edge-detected into one-cycle rising/falling pulses. It sits between board-level pins and all downstream logic, replacing per-pin single-channel conditioners. Unlike them, it has a defined asynchronous reset and a configurable synchroniser depth.

## Interface
Parameters:
- CHANNELS, 4: number of independent input channels (≥1).
- SYNC_STAGES, 2: synchroniser flop depth per channel (≥2).
- COUNTER_WIDTH, 3: debounce counter width in bits.
- WAIT_TIME, 3: consecutive stable cycles beyond the first before a change is accepted. Elaboration error unless 1 ≤ WAIT_TIME < 2**COUNTER_WIDTH.

Ports:
- clk  input  1  system clock (50 MHz nominal); single clock domain.
- reset  input  1  asynchronous, active-high reset.
- noisysignal  input  CHANNELS  raw asynchronous inputs; bit i is channel i.
- conditioned  output  CHANNELS  synchronised, debounced level per channel.
- positiveedge  output  CHANNELS  one-cycle pulse when conditioned[i] goes 0→1.
- negativeedge  output  CHANNELS  one-cycle pulse when conditioned[i] goes 1→0.
- count_clear  input  1  present only with INPUTCOND_EVENT_COUNT_EN; synchronous clear of all event counters.
- event_count  output  8*CHANNELS  present only with INPUTCOND_EVENT_COUNT_EN; channel i occupies bits [8i+7:8i].

## Operation
- Channels are fully independent; no shared state except clk and reset.
- Reset (asynchronous assert, release sampled on clk): all synchroniser flops 0, counters 0, conditioned 0, positiveedge 0, negativeedge 0, event_count 0.
- Synchroniser: noisysignal[i] passes through SYNC_STAGES flops. The last stage is synced[i].
- Debounce FSM per channel, evaluated each rising clk edge:
  - If synced == conditioned, the counter is set to 0.
  - If synced != conditioned and counter == WAIT_TIME, then conditioned ← synced and counter ← 0. The matching edge flag is set to 1 for that cycle.
  - Otherwise the counter increments.
  - Edge flags are 0 on every cycle where no update occurs.
- Glitch rejection: any excursion of synced lasting ≤ WAIT_TIME cycles returns synced to equal conditioned. The counter then resets to 0, and there is no output change and no pulse.
- positiveedge and negativeedge are registered. They are never both high on one channel. Each pulse is high for exactly one cycle, coincident with the first cycle of the new conditioned level.
- Simultaneous events on different channels produce simultaneous, independent pulses.
- Reset mid-count: all state returns to reset values immediately. No pulse is emitted on reset assertion or release.

## Timing
- Latency: a clean input step arriving before clk edge 1 appears on conditioned after edge SYNC_STAGES+WAIT_TIME+1. With defaults, that is edge 6 (120 ns at 50 MHz).
- The edge pulse is asserted in the same cycle that conditioned changes.
- Minimum accepted pulse width on synced: WAIT_TIME+1 cycles. Any shorter pulse is filtered.
- Back-to-back accepted transitions are spaced at least WAIT_TIME+1 cycles apart.
- All outputs are driven directly from flops; there is no combinational path from inputs to outputs.

## Configuration
- Macro: INPUTCOND_EVENT_COUNT_EN.
- When defined:
  - Each channel keeps an 8-bit counter that increments on every positiveedge pulse.
  - The counter saturates at 255.
  - count_clear=1 sets all counters to 0 on the next edge. If a positiveedge occurs in the same cycle, count_clear has priority and the edge is not counted.
  - event_count and count_clear ports exist.
- When undefined: neither the ports nor the counter logic exist, and all other behaviour is identical.

## Structure
- Package inputcond_pkg holds:
  - default constants: DEFAULT_CHANNELS, DEFAULT_SYNC_STAGES, DEFAULT_COUNTER_WIDTH, DEFAULT_WAIT_TIME;
  - EVENT_COUNT_WIDTH = 8;
  - a function that checks WAIT_TIME against COUNTER_WIDTH.
- Sub-module inputcond_channel implements one channel: synchroniser, debounce FSM, edge flags and, when enabled, the event counter. The top level generates CHANNELS instances and concatenates their bits.

## Test plan
- Clean step, defaults: noisysignal[0] 0→1 just after reset release → conditioned[0]=1 after the 6th edge; positiveedge[0]=1 for exactly one cycle; other channels remain 0.
- Glitch: noisysignal[1] high for 2 cycles, then low → conditioned[1], positiveedge[1] and negativeedge[1] stay 0 throughout.
- Bounce: noisysignal[2] toggles 1,0,1,0,1 at one-cycle intervals, then holds 1 → exactly one positiveedge[2], 6 edges after the last toggle. A later 1→0 held step gives exactly one negativeedge[2].
- Simultaneous: channels 0 and 3 step 0→1 on the same edge → both positiveedge bits pulse in the same cycle. Then both step 1→0 → both negativeedge bits pulse in the same cycle.
- Reset mid-count: assert reset 2 cycles after noisysignal[0] rises → all outputs 0 immediately. After release, with input held 1, conditioned[0] rises 6 edges later with one pulse.
- INPUTCOND_EVENT_COUNT_EN:
  - 300 accepted rising edges on channel 1 → event_count[15:8]=255.
  - count_clear for 1 cycle → all counters 0.
  - count_clear coincident with an edge → counter 0.
